// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter.
// Covers FSM state encodings, master indices, the I/O decode default and read latency bounds.
package data_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [7:0] IO_BASE_DEFAULT = 8'hA0;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef struct packed {
        logic        master;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    // Only the low address byte selects between memory and the I/O controllers.
    function automatic logic is_io(input logic [7:0] addr_low, input logic [7:0] io_base);
        return addr_low >= io_base;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// The last-grant pointer is owned by the caller.
module rr_pick2
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);

    // With both requesting, the master that was not granted last time wins.
    always_comb begin
        valid_o  = |req_i;
        winner_o = M0;
        if (req_i[0] && req_i[1]) begin
            winner_o = ~last_i;
        end else if (req_i[1]) begin
            winner_o = M1;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the data bus between the CPU data port (m0) and a secondary master (m1).
// Each grant runs an IDLE -> ISSUE -> (WAIT) -> ACK sequence.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter logic [7:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int         RD_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        mem_we,
    output logic        io_we,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] io_rdata,
    output logic        busy
);

    localparam int         LAT      = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                      (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [1:0] LAST_CNT = 2'(LAT - 1);

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic [1:0]  cnt_q, cnt_d;
    xfer_t       xfer_q, xfer_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        pick;
    logic        pickValid;
    logic        ioSel;
    logic        issueWrite;
    logic [31:0] readData;

    rr_pick2 u_pick (
        .req_i    ({m1_req, m0_req}),
        .last_i   (last_q),
        .winner_o (pick),
        .valid_o  (pickValid)
    );

    assign ioSel    = is_io(xfer_q.addr[7:0], IO_BASE);
    assign readData = ioSel ? io_rdata : mem_rdata;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        xfer_d   = xfer_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    xfer_d.master = pick;
                    xfer_d.we     = (pick == M1) ? m1_we    : m0_we;
                    xfer_d.addr   = (pick == M1) ? m1_addr  : m0_addr;
                    xfer_d.wdata  = (pick == M1) ? m1_wdata : m0_wdata;
                    last_d        = pick;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 2'd0;
                state_d = xfer_q.we ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    if (xfer_q.master == M1) begin
                        rdata1_d = readData;
                    end else begin
                        rdata0_d = readData;
                    end
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer resets to m1 so that m0 wins the first contested grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= M1;
            cnt_q    <= 2'd0;
            xfer_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            xfer_q   <= xfer_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes and acks decode straight from state so an async reset drops them at once.
    assign issueWrite = (state_q == ST_ISSUE) && xfer_q.we;
    assign mem_we     = issueWrite && !ioSel;
    assign io_we      = issueWrite && ioSel;
    assign m0_ack     = (state_q == ST_ACK) && (xfer_q.master == M0);
    assign m1_ack     = (state_q == ST_ACK) && (xfer_q.master == M1);
    assign busy       = (state_q != ST_IDLE);
    assign bus_addr   = xfer_q.addr;
    assign bus_wdata  = xfer_q.wdata;
    assign m0_rdata   = rdata0_q;
    assign m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_bus_arbiter;

    logic        clock;
    logic        reset;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata, mem_rdata, io_rdata;
    logic        mem_we, io_we, busy;

    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_ack, b_m1_ack;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [31:0] b_bus_addr, b_bus_wdata, b_mem_rdata, b_io_rdata;
    logic        b_mem_we, b_io_we, b_busy;

    int checks = 0;
    int errors = 0;

    data_bus_arbiter #(.IO_BASE(8'hA0), .RD_LAT(1)) dutA (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .mem_we(mem_we), .io_we(io_we),
        .mem_rdata(mem_rdata), .io_rdata(io_rdata), .busy(busy)
    );

    data_bus_arbiter #(.IO_BASE(8'hA0), .RD_LAT(3)) dutB (
        .clock(clock), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .mem_we(b_mem_we), .io_we(b_io_we),
        .mem_rdata(b_mem_rdata), .io_rdata(b_io_rdata), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic master, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (master) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // m0 write on dutA from IDLE: ISSUE after the sampling edge, ACK one edge later.
    task automatic runWrite(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic expIo);
        applyStimulus(1'b0, 1'b1, 1'b1, addr, wdata);
        tick();
        checkOutput({tag, "_issue_mem_we"}, {31'd0, mem_we}, {31'd0, !expIo});
        checkOutput({tag, "_issue_io_we"}, {31'd0, io_we}, {31'd0, expIo});
        checkOutput({tag, "_issue_bus_addr"}, bus_addr, addr);
        checkOutput({tag, "_issue_bus_wdata"}, bus_wdata, wdata);
        checkOutput({tag, "_issue_ack"}, {31'd0, m0_ack}, 32'd0);
        tick();
        checkOutput({tag, "_ack"}, {31'd0, m0_ack}, 32'd1);
        checkOutput({tag, "_ack_strobes"}, {30'd0, mem_we, io_we}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, addr, wdata);
        tick();
        checkOutput({tag, "_idle_ack"}, {31'd0, m0_ack}, 32'd0);
        checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_idle_bus_addr"}, bus_addr, addr);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        mem_rdata = 32'h0000_DEAD;
        io_rdata  = 32'h0000_CAFE;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
        b_mem_rdata = 32'h0000_0055;
        b_io_rdata  = 32'h0000_0099;

        repeat (2) tick();
        reset = 1'b0;
        tick();
        $display("[TB] reset values");
        checkOutput("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        checkOutput("rst_strobes", {30'd0, mem_we, io_we}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
        checkOutput("rst_m1_rdata", m1_rdata, 32'd0);

        $display("[TB] m0 memory write");
        runWrite("wr10", 32'h0000_0010, 32'h0000_1234, 1'b0);

        $display("[TB] m1 I/O read, RD_LAT=1");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_00A4, 32'h0);
        tick();
        checkOutput("rd_issue_busy", {31'd0, busy}, 32'd1);
        checkOutput("rd_issue_strobes", {30'd0, mem_we, io_we}, 32'd0);
        checkOutput("rd_issue_bus_addr", bus_addr, 32'h0000_00A4);
        tick();
        checkOutput("rd_wait_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        checkOutput("rd_wait_strobes", {30'd0, mem_we, io_we}, 32'd0);
        tick();
        checkOutput("rd_ack_m1", {31'd0, m1_ack}, 32'd1);
        checkOutput("rd_ack_m0", {31'd0, m0_ack}, 32'd0);
        checkOutput("rd_m1_rdata", m1_rdata, 32'h0000_CAFE);
        checkOutput("rd_m0_rdata", m0_rdata, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_00A4, 32'h0);
        tick();
        checkOutput("rd_idle_ack", {31'd0, m1_ack}, 32'd0);
        checkOutput("rd_m1_rdata_held", m1_rdata, 32'h0000_CAFE);

        $display("[TB] address decode boundary");
        runWrite("wr9F", 32'h0000_009F, 32'h0000_0001, 1'b0);
        runWrite("wrA0", 32'h0000_00A0, 32'h0000_0002, 1'b1);
        runWrite("wrHiA0", 32'h1000_00A0, 32'h0000_0003, 1'b1);

        $display("[TB] reset during WAIT of a read");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        tick();
        checkOutput("rstw_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstw_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstw_strobes", {30'd0, mem_we, io_we}, 32'd0);
        checkOutput("rstw_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rstw_after_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        checkOutput("rstw_after_rdata", m0_rdata, 32'd0);
        runWrite("wrAfterRst", 32'h0000_0050, 32'h0000_0ABC, 1'b0);

        $display("[TB] reset during ISSUE of a write");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0060, 32'h0000_0077);
        tick();
        checkOutput("rsti_pre_mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rsti_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rsti_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rsti_after_ack", {31'd0, m1_ack}, 32'd0);

        $display("[TB] round-robin under continuous contention");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0011);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_00B0, 32'h0000_0022);
        for (int i = 0; i < 4; i++) begin
            logic expM1;
            expM1 = (i % 2) == 1;
            tick();
            checkOutput($sformatf("rr%0d_bus_addr", i), bus_addr, expM1 ? 32'h0000_00B0 : 32'h0000_0030);
            checkOutput($sformatf("rr%0d_mem_we", i), {31'd0, mem_we}, {31'd0, !expM1});
            checkOutput($sformatf("rr%0d_io_we", i), {31'd0, io_we}, {31'd0, expM1});
            tick();
            checkOutput($sformatf("rr%0d_m0_ack", i), {31'd0, m0_ack}, {31'd0, !expM1});
            checkOutput($sformatf("rr%0d_m1_ack", i), {31'd0, m1_ack}, {31'd0, expM1});
            tick();
            checkOutput($sformatf("rr%0d_idle_busy", i), {31'd0, busy}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] memory read, RD_LAT=3");
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h0000_0020;
        tick();
        checkOutput("lat3_issue_bus_addr", b_bus_addr, 32'h0000_0020);
        checkOutput("lat3_issue_busy", {31'd0, b_busy}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput($sformatf("lat3_wait%0d_bus_addr", j), b_bus_addr, 32'h0000_0020);
            checkOutput($sformatf("lat3_wait%0d_ack", j), {31'd0, b_m0_ack}, 32'd0);
            checkOutput($sformatf("lat3_wait%0d_strobes", j), {30'd0, b_mem_we, b_io_we}, 32'd0);
        end
        tick();
        checkOutput("lat3_ack", {31'd0, b_m0_ack}, 32'd1);
        checkOutput("lat3_rdata", b_m0_rdata, 32'h0000_0055);
        checkOutput("lat3_m1_rdata", b_m1_rdata, 32'd0);
        b_m0_req = 1'b0;
        tick();
        checkOutput("lat3_idle_ack", {31'd0, b_m0_ack}, 32'd0);
        checkOutput("lat3_rdata_held", b_m0_rdata, 32'h0000_0055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
